// File: rtl/spi_flash_pkg.sv
// Shared opcodes, FSM encodings and helpers for the SPI-flash responder.
package spi_flash_pkg;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;
    localparam logic [7:0] OP_RDSR      = 8'h05;
    localparam logic [7:0] OP_QREAD     = 8'h6B;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CMD    = 3'd1;
    localparam logic [2:0] ST_ADDR   = 3'd2;
    localparam logic [2:0] ST_DUMMY  = 3'd3;
    localparam logic [2:0] ST_DATA   = 3'd4;
    localparam logic [2:0] ST_STATUS = 3'd5;
    localparam logic [2:0] ST_IGNORE = 3'd6;

    localparam int unsigned DUMMY_CYC_DEFAULT = 8;

    // Byte 0 of a memory word sits in the top byte lane.
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_flash_responder_sync_edge.sv
// Two-flop synchronizer with registered rise/fall pulses for one async input.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta  <= RST_VAL;
            level <= RST_VAL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            meta  <= din;
            level <= meta;
            rise  <= meta & ~level;
            fall  <= ~meta & level;
        end
    end

endmodule

// File: rtl/spi_flash_responder.sv
// SPI-flash target model: READ/FAST_READ/READ_STATUS served from a word memory port.
// Define SPI_FLASH_QUAD_READ_EN to also decode quad output fast read (0x6B).
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int unsigned ADDR_W     = 24,
    parameter int unsigned DUMMY_CYC  = DUMMY_CYC_DEFAULT,
    parameter logic [7:0]  STATUS_VAL = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s,
    input  logic              c,
    input  logic [3:0]        dq_in,
    output logic [3:0]        dq_out,
    output logic [3:0]        dq_oe,
    output logic              mem_req,
    output logic [ADDR_W-3:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              busy,
    output logic [2:0]        debug_state
);

    localparam int unsigned CNT_MAX = (ADDR_W > DUMMY_CYC) ? ADDR_W : DUMMY_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(7);
    localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DUMMY_LAST = CNT_W'(DUMMY_CYC - 1);

    logic s_level, s_fall, c_rise, c_fall;
    logic unused_s_rise, unused_c_level, unused_dq;

    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_s (
        .clk   (clk),
        .rst   (rst),
        .din   (s),
        .level (s_level),
        .rise  (unused_s_rise),
        .fall  (s_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_c (
        .clk   (clk),
        .rst   (rst),
        .din   (c),
        .level (unused_c_level),
        .rise  (c_rise),
        .fall  (c_fall)
    );

    assign unused_dq = ^dq_in[3:1];

    // MOSI delayed by the same two stages as SCK so a rise pulse sees the bit it clocked.
    logic d0_meta, d0_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d0_meta <= 1'b0;
            d0_sync <= 1'b0;
        end else begin
            d0_meta <= dq_in[0];
            d0_sync <= d0_meta;
        end
    end

    logic [2:0]        state,    state_nxt;
    logic [7:0]        op,       op_nxt;
    logic [ADDR_W-1:0] addr,     addr_nxt;
    logic [CNT_W-1:0]  cnt,      cnt_nxt;
    logic [2:0]        bit_cnt,  bit_cnt_nxt;
    logic [31:0]       word,     word_nxt;
    logic              rd_pend,  rd_pend_nxt;
    logic              quad,     quad_nxt;
    logic [3:0]        dq_out_nxt, dq_oe_nxt;
    logic              mem_req_nxt, busy_nxt;
    logic [ADDR_W-3:0] mem_addr_nxt;

    logic [ADDR_W-1:0] addr_shift, addr_inc;
    logic [7:0]        op_shift, data_byte, status_byte;
    logic [3:0]        data_oe;
    logic              byte_last;
    logic [2:0]        bit_step;

    // Next-state and next-output logic.
    always_comb begin
        state_nxt    = state;
        op_nxt       = op;
        addr_nxt     = addr;
        cnt_nxt      = cnt;
        bit_cnt_nxt  = bit_cnt;
        word_nxt     = rd_pend ? mem_rdata : word;
        rd_pend_nxt  = mem_req;
        quad_nxt     = quad;
        dq_out_nxt   = dq_out;
        dq_oe_nxt    = dq_oe;
        mem_req_nxt  = 1'b0;
        mem_addr_nxt = mem_addr;

        addr_shift  = {addr[ADDR_W-2:0], d0_sync};
        addr_inc    = addr + 1'b1;
        op_shift    = {op[6:0], d0_sync};
        data_byte   = 8'(word_byte(word, addr[1:0]) << bit_cnt);
        status_byte = 8'(STATUS_VAL << bit_cnt);
        byte_last   = quad ? bit_cnt[2] : (bit_cnt == 3'd7);
        bit_step    = quad ? 3'd4 : 3'd1;
`ifdef SPI_FLASH_QUAD_READ_EN
        data_oe     = quad ? 4'hF : 4'h2;
`else
        data_oe     = 4'h2;
`endif

        if (s_level) begin
            state_nxt  = ST_IDLE;
            dq_oe_nxt  = 4'h0;
            dq_out_nxt = 4'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (s_fall) begin
                        state_nxt   = ST_CMD;
                        cnt_nxt     = '0;
                        bit_cnt_nxt = 3'd0;
                        quad_nxt    = 1'b0;
                        dq_oe_nxt   = 4'h0;
                        dq_out_nxt  = 4'h0;
                    end
                end
                ST_CMD: begin
                    if (c_rise) begin
                        op_nxt  = op_shift;
                        cnt_nxt = CNT_W'(cnt + 1'b1);
                        if (cnt == CMD_LAST) begin
                            cnt_nxt     = '0;
                            bit_cnt_nxt = 3'd0;
                            case (op_shift)
                                OP_READ, OP_FAST_READ: state_nxt = ST_ADDR;
                                OP_RDSR: begin
                                    state_nxt = ST_STATUS;
                                    dq_oe_nxt = 4'h2;
                                end
`ifdef SPI_FLASH_QUAD_READ_EN
                                OP_QREAD: begin
                                    state_nxt = ST_ADDR;
                                    quad_nxt  = 1'b1;
                                end
`endif
                                default: state_nxt = ST_IGNORE;
                            endcase
                        end
                    end
                end
                ST_ADDR: begin
                    if (c_rise) begin
                        addr_nxt = addr_shift;
                        cnt_nxt  = CNT_W'(cnt + 1'b1);
                        if (cnt == ADDR_LAST) begin
                            cnt_nxt      = '0;
                            bit_cnt_nxt  = 3'd0;
                            mem_req_nxt  = 1'b1;
                            mem_addr_nxt = addr_shift[ADDR_W-1:2];
                            if (op == OP_READ || DUMMY_CYC == 0) begin
                                state_nxt = ST_DATA;
                                dq_oe_nxt = data_oe;
                            end else begin
                                state_nxt = ST_DUMMY;
                            end
                        end
                    end
                end
                ST_DUMMY: begin
                    if (c_rise) begin
                        cnt_nxt = CNT_W'(cnt + 1'b1);
                        if (cnt == DUMMY_LAST) begin
                            cnt_nxt   = '0;
                            state_nxt = ST_DATA;
                            dq_oe_nxt = data_oe;
                        end
                    end
                end
                ST_DATA: begin
                    if (c_fall) begin
                        dq_out_nxt  = quad ? data_byte[7:4] : {2'b00, data_byte[7], 1'b0};
                        bit_cnt_nxt = bit_cnt + bit_step;
                        if (byte_last) begin
                            addr_nxt = addr_inc;
                            // Fetch the following word while its predecessor's last bit is on the wire.
                            if (addr[1:0] == 2'd3) begin
                                mem_req_nxt  = 1'b1;
                                mem_addr_nxt = addr_inc[ADDR_W-1:2];
                            end
                        end
                    end
                end
                ST_STATUS: begin
                    if (c_fall) begin
                        dq_out_nxt  = {2'b00, status_byte[7], 1'b0};
                        bit_cnt_nxt = bit_cnt + 3'd1;
                    end
                end
                ST_IGNORE: begin
                    dq_oe_nxt = 4'h0;
                end
                default: begin
                    state_nxt = ST_IDLE;
                    dq_oe_nxt = 4'h0;
                end
            endcase
        end

        busy_nxt = (state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            op       <= 8'h00;
            addr     <= '0;
            cnt      <= '0;
            bit_cnt  <= 3'd0;
            word     <= 32'h0;
            rd_pend  <= 1'b0;
            quad     <= 1'b0;
            dq_out   <= 4'h0;
            dq_oe    <= 4'h0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            op       <= op_nxt;
            addr     <= addr_nxt;
            cnt      <= cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
            word     <= word_nxt;
            rd_pend  <= rd_pend_nxt;
            quad     <= quad_nxt;
            dq_out   <= dq_out_nxt;
            dq_oe    <= dq_oe_nxt;
            mem_req  <= mem_req_nxt;
            mem_addr <= mem_addr_nxt;
            busy     <= busy_nxt;
        end
    end

    assign debug_state = state;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Self-checking bench: behavioural mode-0 SPI master at clk/8 plus a byte-level flash model.
module tb_spi_flash_responder;
    import spi_flash_pkg::*;

    logic        clk = 1'b0;
    logic        rst, s, c;
    logic [3:0]  dq_in, dq_out, dq_oe;
    logic        mem_req;
    logic [21:0] mem_addr;
    logic [31:0] mem_rdata = 32'h0;
    logic        busy;
    logic [2:0]  debug_state;

    int n_assert = 0;
    int n_fail   = 0;
    int req_cnt  = 0;
    int dbl_req  = 0;
    logic req_prev = 1'b0;
    logic [21:0] req_addr_q[$];
    logic [3:0]  hdr_oe;

    always #5 clk = ~clk;

    spi_flash_responder #(
        .ADDR_W     (24),
        .DUMMY_CYC  (8),
        .STATUS_VAL (8'hA5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s           (s),
        .c           (c),
        .dq_in       (dq_in),
        .dq_out      (dq_out),
        .dq_oe       (dq_oe),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .busy        (busy),
        .debug_state (debug_state)
    );

    // Flash contents: byte at address a = 16*(a/4) + (a%4), truncated to 8 bits.
    function automatic logic [7:0] model_byte(input logic [23:0] a);
        return 8'((32'(a) >> 2) * 16 + 32'(a[1:0]));
    endfunction

    function automatic logic [31:0] model_word(input logic [21:0] w);
        return {model_byte({w, 2'd0}), model_byte({w, 2'd1}),
                model_byte({w, 2'd2}), model_byte({w, 2'd3})};
    endfunction

    always @(posedge clk) begin
        if (mem_req) mem_rdata <= model_word(mem_addr);
    end

    always @(negedge clk) begin
        if (mem_req) begin
            req_cnt++;
            req_addr_q.push_back(mem_addr);
            if (req_prev) dbl_req++;
        end
        req_prev = mem_req;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One SCK period: MOSI set while low, MISO/OE sampled just before the rising edge.
    task automatic xfer(input logic mo, output logic [3:0] mi, output logic [3:0] oe);
        dq_in = {3'b000, mo};
        repeat (4) @(posedge clk);
        #1;
        mi = dq_out;
        oe = dq_oe;
        c  = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        c  = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        logic [3:0] mi, oe;
        for (int i = n - 1; i >= 0; i--) begin
            xfer(v[i], mi, oe);
            hdr_oe |= oe;
        end
    endtask

    task automatic start_cs();
        s = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic end_cs();
        s = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic read_txn(input logic [7:0] op, input logic [23:0] a, input int nb, input string tag);
        logic [3:0]  mi, oe;
        logic [7:0]  rx;
        logic [23:0] ab;
        logic        oe_ok, qd;
        int          req0, exp_req, nd;
        qd      = (op == OP_QREAD);
        nd      = (op == OP_READ) ? 0 : 8;
        req0    = req_cnt;
        exp_req = 1;
        oe_ok   = 1'b1;
        hdr_oe  = 4'h0;
        start_cs();
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        send_bits(32'(op), 8);
        send_bits(32'(a), 24);
        if (nd > 0) send_bits(32'h0, nd);
        chk({tag, "_hdr_oe"}, 32'(hdr_oe), 32'h0);
        for (int b = 0; b < nb; b++) begin
            rx = 8'h00;
            ab = a + 24'(b);
            if (qd) begin
                for (int k = 0; k < 2; k++) begin
                    xfer(1'b0, mi, oe);
                    rx = {rx[3:0], mi};
                    oe_ok &= (oe === 4'hF);
                end
            end else begin
                for (int k = 0; k < 8; k++) begin
                    xfer(1'b0, mi, oe);
                    rx = {rx[6:0], mi[1]};
                    oe_ok &= (oe === 4'h2);
                end
            end
            chk($sformatf("%s_byte%0d", tag, b), 32'(rx), 32'(model_byte(ab)));
            if (ab[1:0] == 2'd3) exp_req++;
        end
        chk({tag, "_data_oe"}, 32'(oe_ok), 32'd1);
        end_cs();
        chk({tag, "_idle"}, {28'h0, busy, debug_state}, 32'(ST_IDLE));
        chk({tag, "_oe_off"}, 32'(dq_oe), 32'h0);
        chk({tag, "_reqs"}, 32'(req_cnt - req0), 32'(exp_req));
    endtask

    task automatic ignore_txn(input logic [7:0] op, input string tag);
        int req0;
        req0   = req_cnt;
        hdr_oe = 4'h0;
        start_cs();
        send_bits(32'(op), 8);
        send_bits($urandom, 32);
        chk({tag, "_state"}, 32'(debug_state), 32'(ST_IGNORE));
        chk({tag, "_oe"}, 32'(hdr_oe), 32'h0);
        end_cs();
        chk({tag, "_idle"}, 32'(debug_state), 32'(ST_IDLE));
        chk({tag, "_reqs"}, 32'(req_cnt - req0), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  mi, oe;
        logic [7:0]  rx, op;
        logic        oe_ok;
        int          req0;

        rst = 1'b1; s = 1'b1; c = 1'b0; dq_in = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", {dq_out, dq_oe, 3'b000, mem_req, 10'h0, mem_addr}, 32'h0);
        chk("reset_state", {28'h0, busy, debug_state}, 32'h0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        read_txn(OP_READ, 24'h000001, 4, "read_a1");
        read_txn(OP_FAST_READ, 24'h000000, 2, "fast_a0");

        // READ_STATUS repeats the constant for as long as CS is held.
        start_cs();
        send_bits(32'(OP_RDSR), 8);
        oe_ok = 1'b1;
        for (int b = 0; b < 2; b++) begin
            rx = 8'h00;
            for (int k = 0; k < 8; k++) begin
                xfer(1'b0, mi, oe);
                rx = {rx[6:0], mi[1]};
                oe_ok &= (oe === 4'h2);
            end
            chk($sformatf("status_byte%0d", b), 32'(rx), 32'hA5);
        end
        chk("status_oe", 32'(oe_ok), 32'd1);
        end_cs();
        chk("status_idle", 32'(debug_state), 32'(ST_IDLE));

        req_addr_q.delete();
        read_txn(OP_READ, 24'hFFFFFF, 2, "read_wrap");
        chk("wrap_nreq", 32'(req_addr_q.size()), 32'd2);
        if (req_addr_q.size() == 2) begin
            chk("wrap_addr0", 32'(req_addr_q[0]), 32'h3FFFFF);
            chk("wrap_addr1", 32'(req_addr_q[1]), 32'h0);
        end

        // Deselect part-way through the address.
        req0 = req_cnt;
        start_cs();
        send_bits(32'(OP_READ), 8);
        send_bits(32'h000ABC, 12);
        s = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_state", 32'(debug_state), 32'(ST_IDLE));
        chk("abort_oe_busy", {27'h0, dq_oe, busy}, 32'h0);
        repeat (20) @(posedge clk);
        #1;
        chk("abort_reqs", 32'(req_cnt - req0), 32'd0);
        read_txn(OP_READ, 24'h000012, 3, "read_after_abort");

        // CS pulse without SCK activity.
        req0 = req_cnt;
        start_cs();
        chk("pulse_busy", 32'(busy), 32'd1);
        end_cs();
        chk("pulse_idle", {28'h0, busy, debug_state}, 32'h0);
        chk("pulse_reqs", 32'(req_cnt - req0), 32'd0);

        // Unsupported opcodes.
        for (int i = 0; i < 3; i++) begin
            do op = 8'($urandom); while (op == OP_READ || op == OP_FAST_READ ||
                                         op == OP_RDSR || op == OP_QREAD);
            ignore_txn(op, $sformatf("ignore_%02h", op));
        end

`ifdef SPI_FLASH_QUAD_READ_EN
        read_txn(OP_QREAD, 24'h000000, 2, "quad_a0");
        read_txn(OP_QREAD, 24'($urandom), 5, "quad_rand");
`else
        ignore_txn(OP_QREAD, "quad_disabled");
`endif

        for (int i = 0; i < 6; i++) begin
            read_txn(($urandom_range(0, 1) == 0) ? OP_READ : OP_FAST_READ,
                     24'($urandom), $urandom_range(1, 6), $sformatf("rand%0d", i));
        end

        // Reset while data is streaming.
        start_cs();
        send_bits(32'(OP_READ), 8);
        send_bits(32'h000020, 24);
        send_bits(32'h0, 12);
        chk("mid_data_state", 32'(debug_state), 32'(ST_DATA));
        rst = 1'b1;
        #1;
        chk("rst_mid_outs", {dq_out, dq_oe, 3'b000, mem_req, 10'h0, mem_addr}, 32'h0);
        chk("rst_mid_state", {28'h0, busy, debug_state}, 32'h0);
        s = 1'b1;
        c = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        read_txn(OP_READ, 24'h000102, 2, "read_after_rst");

        chk("no_back_to_back_req", 32'(dbl_req), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
